// File: rtl/regf_mp_pkg.sv
// Shared register-file types and defaults for the integer and FPU register files.
package regf_mp_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] regdata_t;

  // Decode wrapper packs read ports 0/1 into this pair.
  typedef struct packed {
    regdata_t rs2;
    regdata_t rs1;
  } regvpair;

endpackage

// File: rtl/regf_scoreboard.sv
// Per-register busy scoreboard: a claim sets a bit, a write clears it, and the claim wins on a tie.
module regf_scoreboard #(
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREG-1:0] clr,
  input  logic            claim_enable,
  input  logic [AW-1:0]   claim_addr,
  output logic [NREG-1:0] busy,
  output logic [NREG-1:0] busy_next
);

  logic [NREG-1:0] claim_vec;

  always_comb begin
    claim_vec = '0;
    if (claim_enable) claim_vec[claim_addr] = 1'b1;
    if (ZERO_REG != 0) claim_vec[0] = 1'b0;
  end

  // A new producer supersedes a retiring one, so the set term is ORed in last.
  assign busy_next = (busy & ~clr) | claim_vec;

  always_ff @(posedge clk) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/regf_mp.sv
// Parametrised multi-port register file with write-to-read forwarding, optional zero register
// and a busy scoreboard for long-latency producers.
module regf_mp
  import regf_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREG     = NREG_DEFAULT,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                r_enabled,
  input  logic [NRD*AW-1:0]   r_addr,
  output logic [NRD*XLEN-1:0] r_data,
  output logic [NRD-1:0]      r_busy,
  input  logic [NWR-1:0]      w_enable,
  input  logic [NWR*AW-1:0]   w_addr,
  input  logic [NWR*XLEN-1:0] w_data,
  input  logic                claim_enable,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREG-1:0]     busy
);

  // Contents survive rstn; they start at zero only at configuration.
  logic [XLEN-1:0] regs [NREG] = '{default: '0};

  logic [NREG-1:0] w_hit;
  logic [XLEN-1:0] w_val [NREG];
  logic [NREG-1:0] busy_next;
  logic [NRD*XLEN-1:0] rd_next;
  logic [NRD-1:0]      rb_next;

  // Per-register write select; scanning ports upward lets the highest index win.
  for (genvar i = 0; i < NREG; i++) begin : g_wr
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign w_hit[i] = 1'b0;
      assign w_val[i] = '0;
    end else begin : g_sel
      logic            hit;
      logic [XLEN-1:0] val;
      always_comb begin
        hit = 1'b0;
        val = '0;
        for (int p = 0; p < NWR; p++) begin
          if (w_enable[p] && w_addr[p*AW +: AW] == AW'(i)) begin
            hit = 1'b1;
            val = w_data[p*XLEN +: XLEN];
          end
        end
      end
      assign w_hit[i] = hit;
      assign w_val[i] = val;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_hit[i]) regs[i] <= w_val[i];
      end
    end
  end

  regf_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (w_hit),
    .claim_enable (claim_enable),
    .claim_addr   (claim_addr),
    .busy         (busy),
    .busy_next    (busy_next)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = r_addr[k*AW +: AW];
    assign rd_next[k*XLEN +: XLEN] = (ZERO_REG != 0 && a == '0) ? '0 :
                                     w_hit[a] ? w_val[a] : regs[a];
    assign rb_next[k] = busy_next[a];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data <= '0;
      r_busy <= '0;
    end else if (r_enabled) begin
      r_data <= rd_next;
      r_busy <= rb_next;
    end
  end

endmodule

// File: tb/tb_regf_mp.sv
// Directed checks of the default and FPU-style register files, plus a wide-configuration sweep.
module tb_regf_mp;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Default instance (ZERO_REG=1) and an FPU-style twin (ZERO_REG=0) share stimulus.
  logic        r_enabled;
  logic [9:0]  r_addr;
  logic [63:0] r_data, r_data_z;
  logic [1:0]  r_busy, r_busy_z;
  logic [1:0]  w_enable;
  logic [9:0]  w_addr;
  logic [63:0] w_data;
  logic        claim_enable;
  logic [4:0]  claim_addr;
  logic [31:0] busy, busy_z;

  // Sweep instance: NRD=3, NWR=1, XLEN=64, NREG=64.
  logic         s_r_enabled;
  logic [17:0]  s_r_addr;
  logic [191:0] s_r_data;
  logic [2:0]   s_r_busy;
  logic [0:0]   s_w_enable;
  logic [5:0]   s_w_addr;
  logic [63:0]  s_w_data;
  logic         s_claim_enable;
  logic [5:0]   s_claim_addr;
  logic [63:0]  s_busy;

  regf_mp u_dut (
    .clk(clk), .rstn(rstn), .r_enabled(r_enabled), .r_addr(r_addr), .r_data(r_data),
    .r_busy(r_busy), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .claim_enable(claim_enable), .claim_addr(claim_addr), .busy(busy)
  );

  regf_mp #(.ZERO_REG(0)) u_dut_z (
    .clk(clk), .rstn(rstn), .r_enabled(r_enabled), .r_addr(r_addr), .r_data(r_data_z),
    .r_busy(r_busy_z), .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .claim_enable(claim_enable), .claim_addr(claim_addr), .busy(busy_z)
  );

  regf_mp #(.XLEN(64), .NREG(64), .NRD(3), .NWR(1)) u_dut_s (
    .clk(clk), .rstn(rstn), .r_enabled(s_r_enabled), .r_addr(s_r_addr), .r_data(s_r_data),
    .r_busy(s_r_busy), .w_enable(s_w_enable), .w_addr(s_w_addr), .w_data(s_w_data),
    .claim_enable(s_claim_enable), .claim_addr(s_claim_addr), .busy(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_enable     = '0;
    w_addr       = '0;
    w_data       = '0;
    claim_enable = 1'b0;
    claim_addr   = '0;
  endtask

  // Reference state for the sweep instance.
  logic [63:0]  m_regs [64];
  logic [63:0]  m_busy, m_bn;
  logic [191:0] m_rd;
  logic [2:0]   m_rb;
  logic [5:0]   m_a;

  initial begin
    r_enabled = 1'b0;
    r_addr    = '0;
    idle_inputs();
    s_r_enabled = 1'b0; s_r_addr = '0; s_w_enable = '0; s_w_addr = '0;
    s_w_data = '0; s_claim_enable = 1'b0; s_claim_addr = '0;
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    m_busy = '0; m_rd = '0; m_rb = '0;

    step(); step();
    check("rst_rdata", r_data, 64'h0);
    check("rst_rbusy", r_busy, 2'b00);
    check("rst_busy", busy, 32'h0);
    check("rst_busy_z", busy_z, 32'h0);
    check("rst_s_rdata", s_r_data, 192'h0);
    check("rst_s_busy", s_busy, 64'h0);
    rstn = 1'b1;

    // Write x5, read it back next cycle.
    w_enable = 2'b01; w_addr = {5'd0, 5'd5}; w_data = {32'h0, 32'h1234_5678};
    step();
    idle_inputs();
    r_enabled = 1'b1; r_addr = {5'd0, 5'd5};
    step();
    check("t1_read_x5", r_data, {32'h0, 32'h1234_5678});

    // Both ports write x7; port 1 wins and is forwarded to both readers.
    w_enable = 2'b11; w_addr = {5'd7, 5'd7}; w_data = {32'h5555_5555, 32'hAAAA_AAAA};
    r_addr = {5'd7, 5'd7};
    step();
    check("t2_bypass_prio", r_data, {32'h5555_5555, 32'h5555_5555});
    idle_inputs();
    step();
    check("t2_commit", r_data, {32'h5555_5555, 32'h5555_5555});

    // Write and claim x0: ignored by the integer file, honoured by the FPU file.
    w_enable = 2'b01; w_addr = {5'd0, 5'd0}; w_data = {32'h0, 32'hFFFF_FFFF};
    claim_enable = 1'b1; claim_addr = 5'd0; r_addr = {5'd0, 5'd0};
    step();
    check("t3_z1_rdata", r_data, 64'h0);
    check("t3_z1_rbusy", r_busy, 2'b00);
    check("t3_z1_busy", busy, 32'h0);
    check("t3_z0_rdata", r_data_z, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check("t3_z0_rbusy", r_busy_z, 2'b11);
    check("t3_z0_busy", busy_z, 32'h1);
    idle_inputs();
    step();
    check("t3_z1_rdata2", r_data, 64'h0);
    check("t3_z0_rdata2", r_data_z, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check("t3_z0_rbusy2", r_busy_z, 2'b11);

    // Scoreboard: claim, hold, clear by write, claim beats write.
    claim_enable = 1'b1; claim_addr = 5'd9; r_addr = {5'd9, 5'd9};
    step();
    check("t4_claim_busy", busy, 32'h0000_0200);
    check("t4_claim_rbusy", r_busy, 2'b11);
    idle_inputs();
    step();
    check("t4_hold_busy", busy, 32'h0000_0200);
    check("t4_hold_rbusy", r_busy, 2'b11);
    w_enable = 2'b10; w_addr = {5'd9, 5'd0}; w_data = {32'd3, 32'd0};
    step();
    check("t4_wr_rdata", r_data, {32'd3, 32'd3});
    check("t4_wr_rbusy", r_busy, 2'b00);
    check("t4_wr_busy", busy, 32'h0);
    w_enable = 2'b01; w_addr = {5'd0, 5'd9}; w_data = {32'd0, 32'h77};
    claim_enable = 1'b1; claim_addr = 5'd9;
    step();
    check("t4_both_rdata", r_data, {32'h77, 32'h77});
    check("t4_both_rbusy", r_busy, 2'b11);
    check("t4_both_busy", busy, 32'h0000_0200);

    // Hold: r_enabled low while addresses and x9 change.
    idle_inputs();
    r_enabled = 1'b0; r_addr = {5'd5, 5'd7};
    w_enable = 2'b01; w_addr = {5'd0, 5'd9}; w_data = {32'd0, 32'h99};
    step();
    check("t5_hold_rdata", r_data, {32'h77, 32'h77});
    check("t5_hold_rbusy", r_busy, 2'b11);
    check("t5_hold_busy", busy, 32'h0);
    idle_inputs();
    claim_enable = 1'b1; claim_addr = 5'd9;
    step();
    check("t5_reclaim_busy", busy, 32'h0000_0200);
    check("t5_hold_rdata2", r_data, {32'h77, 32'h77});

    // Reset with a pending write to x3: write dropped, outputs cleared.
    idle_inputs();
    rstn = 1'b0; r_enabled = 1'b1; r_addr = {5'd3, 5'd3};
    w_enable = 2'b01; w_addr = {5'd0, 5'd3}; w_data = {32'd0, 32'd9};
    step();
    check("t5_rst_rdata", r_data, 64'h0);
    check("t5_rst_rbusy", r_busy, 2'b00);
    check("t5_rst_busy", busy, 32'h0);
    rstn = 1'b1;
    idle_inputs();
    r_addr = {5'd9, 5'd3};
    step();
    check("t5_after_rdata", r_data, {32'h99, 32'h0});
    check("t5_after_busy", busy, 32'h0);
    r_enabled = 1'b0;

    // Wide configuration against a reference model; small address range forces collisions.
    for (int c = 0; c < 2000; c++) begin
      s_w_enable     = 1'($urandom_range(0, 1));
      s_w_addr       = 6'($urandom_range(0, 15));
      s_w_data       = {$urandom, $urandom};
      s_claim_enable = ($urandom_range(0, 3) == 0);
      s_claim_addr   = 6'($urandom_range(0, 15));
      s_r_enabled    = ($urandom_range(0, 3) != 0);
      s_r_addr       = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
                        6'($urandom_range(0, 15))};

      m_bn = m_busy;
      if (s_w_enable[0] && s_w_addr != 0) m_bn[s_w_addr] = 1'b0;
      if (s_claim_enable && s_claim_addr != 0) m_bn[s_claim_addr] = 1'b1;
      if (s_r_enabled) begin
        for (int k = 0; k < 3; k++) begin
          m_a = s_r_addr[k*6 +: 6];
          if (m_a == 0)                              m_rd[k*64 +: 64] = '0;
          else if (s_w_enable[0] && s_w_addr == m_a) m_rd[k*64 +: 64] = s_w_data;
          else                                       m_rd[k*64 +: 64] = m_regs[m_a];
          m_rb[k] = m_bn[m_a];
        end
      end
      if (s_w_enable[0] && s_w_addr != 0) m_regs[s_w_addr] = s_w_data;
      m_busy = m_bn;

      step();
      check("sweep_rdata", s_r_data, m_rd);
      check("sweep_rbusy", s_r_busy, m_rb);
      check("sweep_busy", s_busy, m_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
